// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Port indices: data cache controller and instruction cache
  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  // Arbitration policies
  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request picker: round-robin on ties, or fixed priority to port 0.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Pick a winner; on a tie round-robin favours the port that did not win last
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = PORT_D;
    unique case (req_i)
      2'b01:   gnt_idx_o = PORT_D;
      2'b10:   gnt_idx_o = PORT_I;
      2'b11:   gnt_idx_o = (mode_i == PRIO_FIXED) ? PORT_D : ~last_i;
      default: gnt_idx_o = PORT_D;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one off-chip memory port between the dcache controller (port 0)
// and the instruction cache (port 1), one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              timeout_o
);

  // Counter is wide enough to hold TIMEOUT, so saturation never hides the threshold
  localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             ARB_MODE = (PRIO_MODE != 0) ? PRIO_FIXED : PRIO_RR;

  state_e              state_q;
  logic                grant_q;
  logic                last_q;
  logic                mem_en_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic                busy_q;
  logic                timeout_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                gnt_valid;
  logic                gnt_idx;
  logic                wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                timeout_hit;

  rr_arb2 u_pick (
    .req_i       ({p1_enable_i, p0_enable_i}),
    .last_i      (last_q),
    .mode_i      (ARB_MODE),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Route the winning port's command fields toward the output registers
  always_comb begin
    wr_d   = p0_write_i;
    addr_d = p0_addr_i;
    data_d = p0_data_i;
    if (gnt_idx == PORT_I) begin
      wr_d   = p1_write_i;
      addr_d = p1_addr_i;
      data_d = p1_data_i;
    end
  end

  // Saturating wait count and watchdog threshold on the count being entered
  always_comb begin
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (32'(cnt_d) >= TIMEOUT - 1);
  end

  // Transaction FSM with registered memory command, busy and watchdog flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= PORT_D;
      last_q     <= PORT_I;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q    <= BUSY;
            grant_q    <= gnt_idx;
            last_q     <= gnt_idx;
            mem_en_q   <= 1'b1;
            mem_wr_q   <= wr_d;
            mem_addr_q <= addr_d;
            mem_data_q <= data_d;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_d;
          if (mem_ack_i) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

  // Read data is broadcast; the ack qualifies it for the granted port only
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;
  assign p0_ack_o  = mem_ack_i & (state_q == BUSY) & (grant_q == PORT_D);
  assign p1_ack_o  = mem_ack_i & (state_q == BUSY) & (grant_q == PORT_I);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with an 8-cycle
// watchdog and a fixed-priority instance share the same stimulus.
module tb_mem_arbiter;

  localparam logic [255:0] PAT_AA = {32{8'hAA}};
  localparam logic [255:0] PAT_55 = {32{8'h55}};
  localparam logic [255:0] PAT_RD = {8{32'hDEADBEEF}};

  logic         clk;
  logic         rst;
  logic         p0_en, p0_wr, p1_en, p1_wr;
  logic [31:0]  p0_addr, p1_addr;
  logic [255:0] p0_wdata, p1_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  logic [255:0] rr_p0_rdata, rr_p1_rdata, rr_mem_wdata;
  logic         rr_p0_ack, rr_p1_ack, rr_mem_en, rr_mem_wr, rr_busy, rr_timeout;
  logic [31:0]  rr_mem_addr;
  logic [255:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata;
  logic         fp_p0_ack, fp_p1_ack, fp_mem_en, fp_mem_wr, fp_busy, fp_timeout;
  logic [31:0]  fp_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DATA_W(256), .ADDR_W(32), .PRIO_MODE(0), .TIMEOUT(8)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_data_o(rr_p0_rdata), .p0_ack_o(rr_p0_ack),
    .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_data_o(rr_p1_rdata), .p1_ack_o(rr_p1_ack),
    .mem_enable_o(rr_mem_en), .mem_write_o(rr_mem_wr), .mem_addr_o(rr_mem_addr),
    .mem_data_o(rr_mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .busy_o(rr_busy), .timeout_o(rr_timeout)
  );

  mem_arbiter #(.DATA_W(256), .ADDR_W(32), .PRIO_MODE(1), .TIMEOUT(0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_data_o(fp_p0_rdata), .p0_ack_o(fp_p0_ack),
    .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_data_o(fp_p1_rdata), .p1_ack_o(fp_p1_ack),
    .mem_enable_o(fp_mem_en), .mem_write_o(fp_mem_wr), .mem_addr_o(fp_mem_addr),
    .mem_data_o(fp_mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .busy_o(fp_busy), .timeout_o(fp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    p0_en = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_en = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_tests++; if (rr_mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %0h want 0", rr_mem_en); end
    n_tests++; if (rr_mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got %0h want 0", rr_mem_wr); end
    n_tests++; if (rr_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %0h want 0", rr_mem_addr); end
    n_tests++; if (rr_mem_wdata !== 256'h0) begin n_fail++; $display("FAIL reset_mem_data got %0h want 0", rr_mem_wdata); end
    n_tests++; if (rr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", rr_busy); end
    n_tests++; if (rr_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %0h want 0", rr_timeout); end
    n_tests++; if (fp_mem_en !== 1'b0 || fp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fp got en=%0h busy=%0h want 0 0", fp_mem_en, fp_busy); end
    // Stray ack in IDLE must not reach either port
    mem_ack = 1'b1; mem_rdata = PAT_RD;
    #1;
    n_tests++; if (rr_p0_ack !== 1'b0 || rr_p1_ack !== 1'b0) begin n_fail++; $display("FAIL stray_ack got %0h%0h want 00", rr_p1_ack, rr_p0_ack); end
    step();
    mem_ack = 1'b0;
    n_tests++; if (rr_mem_en !== 1'b0 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL stray_ack_idle got en=%0h busy=%0h want 0 0", rr_mem_en, rr_busy); end
  endtask

  task automatic test_single_read();
    int c0, c1;
    clear_inputs();
    do_reset();
    p0_en = 1'b1; p0_wr = 1'b0; p0_addr = 32'h40;
    #1;
    n_tests++; if (rr_mem_en !== 1'b0) begin n_fail++; $display("FAIL read_latency_n got %0h want 0", rr_mem_en); end
    step();
    n_tests++; if (rr_mem_en !== 1'b1) begin n_fail++; $display("FAIL read_en_n1 got %0h want 1", rr_mem_en); end
    n_tests++; if (rr_mem_addr !== 32'h40) begin n_fail++; $display("FAIL read_addr got %0h want 40", rr_mem_addr); end
    n_tests++; if (rr_mem_wr !== 1'b0) begin n_fail++; $display("FAIL read_wr got %0h want 0", rr_mem_wr); end
    n_tests++; if (rr_busy !== 1'b1) begin n_fail++; $display("FAIL read_busy got %0h want 1", rr_busy); end
    c0 = 0; c1 = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 10) begin mem_ack = 1'b1; mem_rdata = PAT_RD; end
      #1;
      if (rr_p0_ack === 1'b1) c0++;
      if (rr_p1_ack === 1'b1) c1++;
      if (k == 10) begin
        n_tests++; if (rr_p0_rdata !== PAT_RD) begin n_fail++; $display("FAIL read_data got %0h want %0h", rr_p0_rdata, PAT_RD); end
      end
    end
    step();
    mem_ack = 1'b0; p0_en = 1'b0;
    #1;
    if (rr_p0_ack === 1'b1) c0++;
    n_tests++; if (rr_mem_en !== 1'b0 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL read_done got en=%0h busy=%0h want 0 0", rr_mem_en, rr_busy); end
    n_tests++; if (c0 != 1) begin n_fail++; $display("FAIL read_p0_ack_pulses got %0d want 1", c0); end
    n_tests++; if (c1 != 0) begin n_fail++; $display("FAIL read_p1_ack_pulses got %0d want 0", c1); end
  endtask

  task automatic test_round_robin();
    logic exp;
    clear_inputs();
    do_reset();
    p0_en = 1'b1; p0_addr = 32'h100;
    p1_en = 1'b1; p1_addr = 32'h200;
    step();
    for (int t = 0; t < 4; t++) begin
      exp = t[0];
      n_tests++; if (rr_mem_addr !== (exp ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL rr_addr_%0d got %0h want %0h", t, rr_mem_addr, exp ? 32'h200 : 32'h100); end
      n_tests++; if (fp_mem_addr !== 32'h100) begin n_fail++; $display("FAIL fp_addr_%0d got %0h want 100", t, fp_mem_addr); end
      step();
      step();
      mem_ack = 1'b1; mem_rdata = PAT_RD;
      #1;
      n_tests++; if ({rr_p1_ack, rr_p0_ack} !== (exp ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ack_%0d got %b%b want %0d", t, rr_p1_ack, rr_p0_ack, exp); end
      n_tests++; if ({fp_p1_ack, fp_p0_ack} !== 2'b01) begin n_fail++; $display("FAIL fp_ack_%0d got %b%b want 01", t, fp_p1_ack, fp_p0_ack); end
      step();
      mem_ack = 1'b0;
      if (t == 3) begin p0_en = 1'b0; p1_en = 1'b0; end
      n_tests++; if (rr_mem_en !== 1'b0 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL rr_gap_%0d got en=%0h busy=%0h want 0 0", t, rr_mem_en, rr_busy); end
      step();
      n_tests++; if (rr_mem_en !== (t < 3)) begin n_fail++; $display("FAIL rr_regrant_%0d got %0h want %0h", t, rr_mem_en, t < 3); end
    end
  endtask

  task automatic test_fixed_priority();
    clear_inputs();
    do_reset();
    p0_en = 1'b1; p0_addr = 32'h140;
    p1_en = 1'b1; p1_addr = 32'h240;
    step();
    for (int t = 0; t < 3; t++) begin
      n_tests++; if (fp_mem_addr !== ((t < 2) ? 32'h140 : 32'h240)) begin n_fail++; $display("FAIL fixed_addr_%0d got %0h want %0h", t, fp_mem_addr, (t < 2) ? 32'h140 : 32'h240); end
      step();
      step();
      mem_ack = 1'b1;
      #1;
      n_tests++; if ({fp_p1_ack, fp_p0_ack} !== ((t < 2) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL fixed_ack_%0d got %b%b want %0d", t, fp_p1_ack, fp_p0_ack, (t < 2) ? 0 : 1); end
      step();
      mem_ack = 1'b0;
      if (t == 1) p0_en = 1'b0;
      if (t == 2) p1_en = 1'b0;
      step();
      n_tests++; if (fp_mem_en !== (t < 2)) begin n_fail++; $display("FAIL fixed_regrant_%0d got %0h want %0h", t, fp_mem_en, t < 2); end
    end
  endtask

  task automatic test_write_frozen();
    clear_inputs();
    do_reset();
    p1_en = 1'b1; p1_wr = 1'b1; p1_addr = 32'h80; p1_wdata = PAT_AA;
    step();
    p0_en = 1'b1; p0_wr = 1'b1; p0_addr = 32'h300; p0_wdata = PAT_55;
    p1_addr = 32'hC0; p1_wdata = PAT_55;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (rr_mem_addr !== 32'h80 || rr_mem_wr !== 1'b1) begin n_fail++; $display("FAIL frozen_cmd_%0d got addr=%0h wr=%0h want 80 1", k, rr_mem_addr, rr_mem_wr); end
      n_tests++; if (rr_mem_wdata !== PAT_AA) begin n_fail++; $display("FAIL frozen_data_%0d got %0h want %0h", k, rr_mem_wdata, PAT_AA); end
      step();
    end
    mem_ack = 1'b1;
    #1;
    n_tests++; if ({rr_p1_ack, rr_p0_ack} !== 2'b10) begin n_fail++; $display("FAIL frozen_ack got %b%b want 10", rr_p1_ack, rr_p0_ack); end
    step();
    mem_ack = 1'b0; p1_en = 1'b0;
    step();
    n_tests++; if (rr_mem_addr !== 32'h300 || rr_mem_wdata !== PAT_55) begin n_fail++; $display("FAIL frozen_next got addr=%0h data=%0h want 300 %0h", rr_mem_addr, rr_mem_wdata, PAT_55); end
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; p0_en = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    clear_inputs();
    do_reset();
    p0_en = 1'b1; p0_addr = 32'h40;
    step();
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      n_tests++; if (rr_timeout !== (k >= 8)) begin n_fail++; $display("FAIL timeout_busy_%0d got %0h want %0h", k, rr_timeout, k >= 8); end
    end
    n_tests++; if (fp_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_disabled got %0h want 0", fp_timeout); end
    step();
    mem_ack = 1'b1; mem_rdata = PAT_AA;
    #1;
    n_tests++; if (rr_p0_ack !== 1'b1 || rr_p0_rdata !== PAT_AA) begin n_fail++; $display("FAIL timeout_late_ack got ack=%0h data=%0h want 1 %0h", rr_p0_ack, rr_p0_rdata, PAT_AA); end
    step();
    mem_ack = 1'b0; p0_en = 1'b0;
    n_tests++; if (rr_busy !== 1'b0 || rr_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_after_ack got busy=%0h to=%0h want 0 1", rr_busy, rr_timeout); end
    step();
    step();
    n_tests++; if (rr_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %0h want 1", rr_timeout); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (rr_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %0h want 0", rr_timeout); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    do_reset();
    p0_en = 1'b1; p0_wr = 1'b1; p0_addr = 32'h40; p0_wdata = PAT_AA;
    step();
    step();
    step();
    rst = 1'b1; p0_en = 1'b0;
    step();
    rst = 1'b0;
    n_tests++; if (rr_mem_en !== 1'b0 || rr_mem_wr !== 1'b0 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got en=%0h wr=%0h busy=%0h want 0 0 0", rr_mem_en, rr_mem_wr, rr_busy); end
    n_tests++; if (rr_mem_addr !== 32'h0 || rr_mem_wdata !== 256'h0) begin n_fail++; $display("FAIL midrst_cmd got addr=%0h data=%0h want 0 0", rr_mem_addr, rr_mem_wdata); end
    step();
    mem_ack = 1'b1;
    #1;
    n_tests++; if ({rr_p1_ack, rr_p0_ack, fp_p1_ack, fp_p0_ack} !== 4'b0000) begin n_fail++; $display("FAIL midrst_late_ack got %b%b%b%b want 0000", rr_p1_ack, rr_p0_ack, fp_p1_ack, fp_p0_ack); end
    step();
    mem_ack = 1'b0;
    n_tests++; if (rr_mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %0h want 0", rr_mem_en); end
  endtask

  task automatic test_drop_early();
    clear_inputs();
    do_reset();
    p1_en = 1'b1; p1_addr = 32'h1C0;
    step();
    step();
    p1_en = 1'b0;
    step();
    step();
    mem_ack = 1'b1; mem_rdata = PAT_55;
    #1;
    n_tests++; if ({rr_p1_ack, rr_p0_ack} !== 2'b10) begin n_fail++; $display("FAIL drop_ack got %b%b want 10", rr_p1_ack, rr_p0_ack); end
    n_tests++; if (rr_p1_rdata !== PAT_55) begin n_fail++; $display("FAIL drop_data got %0h want %0h", rr_p1_rdata, PAT_55); end
    step();
    mem_ack = 1'b0;
    n_tests++; if (rr_mem_en !== 1'b0 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL drop_done got en=%0h busy=%0h want 0 0", rr_mem_en, rr_busy); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_frozen();
    test_timeout();
    test_reset_mid();
    test_drop_early();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
